// File: rtl/comparador_iterativo_serie_pkg.sv
// Shared encodings for the bit-serial comparator: FSM states, relation codes,
// running-comparison codes and small helpers used by the datapath.
package comparador_iterativo_serie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LE = 2'b00;
  localparam logic [1:0] OP_LT = 2'b01;
  localparam logic [1:0] OP_EQ = 2'b10;
  localparam logic [1:0] OP_GE = 2'b11;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Index register width; a 1-bit word still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Maps the final running comparison onto the requested relation.
  function automatic logic resolve(input logic [1:0] op, input logic [1:0] cmp);
    logic r;
    r = 1'b0;
    case (op)
      OP_LE:   r = (cmp != CMP_GT);
      OP_LT:   r = (cmp == CMP_LT);
      OP_EQ:   r = (cmp == CMP_EQ);
      default: r = (cmp != CMP_LT);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparador_iterativo_serie_if.sv
// Request/result bundle of the serial comparator, plus FSM debug visibility.
//
// Handshake: start is sampled only while busy=0; an accepted start latches
// A, B, dir and op. busy stays high until the cycle after the one-cycle done
// pulse; Zout is valid from done and held until the next done.
interface comparador_iterativo_serie_if #(
  parameter int N = 3
);
  import comparador_iterativo_serie_pkg::*;

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         dir;
  logic [1:0]   op;
  logic         busy;
  logic         done;
  logic         Zout;
  state_t       estado;
  logic [1:0]   cmp_dbg;

  modport master (
    output start, A, B, dir, op,
    input  busy, done, Zout, estado, cmp_dbg
  );

  modport slave (
    input  start, A, B, dir, op,
    output busy, done, Zout, estado, cmp_dbg
  );

endinterface

// File: rtl/comparador_iterativo_serie_celda_comparacion.sv
// One stage of the iterative comparator network, reused once per clock by the
// serial datapath. Purely combinational.
module celda_comparacion
  import comparador_iterativo_serie_pkg::*;
(
  input  logic [1:0] cmp_in,
  input  logic       a,
  input  logic       b,
  input  logic       dir,
  output logic [1:0] cmp_out
);

  // LSB-first: a later (more significant) differing bit overrides.
  // MSB-first: the first differing bit decides and the result is frozen.
  always_comb begin
    cmp_out = cmp_in;
    if (a != b) begin
      if (!dir || (cmp_in == CMP_EQ)) begin
        cmp_out = a ? CMP_GT : CMP_LT;
      end
    end
  end

endmodule

// File: rtl/comparador_iterativo_serie.sv
// Bit-serial N-bit comparator: one bit pair per clock through a single
// comparison cell, LSB-first or MSB-first, with optional MSB-first early exit.
module comparador_iterativo_serie
  import comparador_iterativo_serie_pkg::*;
#(
  parameter int N          = 3,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  comparador_iterativo_serie_if.slave bus
);

  localparam int             IW       = idx_w(N);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [N-1:0]   a_sh, b_sh;
  logic           dir_q;
  logic [1:0]     op_q;
  logic [1:0]     cmp_q, cmp_nxt;
  logic [IW-1:0]  idx_q;
  logic           zout_q;
  logic           a_bit, b_bit;
  logic           last_bit;
  logic           decided;
  logic           fin;

  // Shifting instead of bit-selecting keeps the N=1 case free of a
  // zero-width index.
  always_comb begin
    a_sh  = a_q >> idx_q;
    b_sh  = b_q >> idx_q;
    a_bit = a_sh[0];
    b_bit = b_sh[0];
  end

  celda_comparacion u_celda (
    .cmp_in  (cmp_q),
    .a       (a_bit),
    .b       (b_bit),
    .dir     (dir_q),
    .cmp_out (cmp_nxt)
  );

  always_comb begin
    last_bit = dir_q ? (idx_q == '0) : (idx_q == IDX_LAST);
    decided  = EARLY_EXIT && dir_q && (a_bit != b_bit);
    fin      = last_bit || decided;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (fin)       state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      dir_q  <= 1'b0;
      op_q   <= OP_LE;
      cmp_q  <= CMP_EQ;
      idx_q  <= '0;
      zout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            dir_q <= bus.dir;
            op_q  <= bus.op;
            cmp_q <= CMP_EQ;
            idx_q <= bus.dir ? IDX_LAST : '0;
          end
        end
        ST_RUN: begin
          cmp_q <= cmp_nxt;
          // The index only moves while bits remain, so it never wraps.
          if (fin) begin
            zout_q <= resolve(op_q, cmp_nxt);
          end else begin
            idx_q <= dir_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.Zout    = zout_q;
  assign bus.estado  = state_q;
  assign bus.cmp_dbg = cmp_q;

endmodule

// File: tb/tb_comparador_iterativo_serie.sv
// Directed bench for the serial comparator: three builds (N=3, N=3 with early
// exit, N=1) driven from one sequence with hand-derived expectations.
module tb_comparador_iterativo_serie;
  import comparador_iterativo_serie_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  comparador_iterativo_serie_if #(.N(3)) bus3  ();
  comparador_iterativo_serie_if #(.N(3)) bus3e ();
  comparador_iterativo_serie_if #(.N(1)) bus1  ();

  comparador_iterativo_serie #(.N(3), .EARLY_EXIT(1'b0)) dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  comparador_iterativo_serie #(.N(3), .EARLY_EXIT(1'b1)) dut3e (.clk(clk), .rst_n(rst_n), .bus(bus3e));
  comparador_iterativo_serie #(.N(1), .EARLY_EXIT(1'b0)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        last_z[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [2:0] a, input logic [2:0] b,
                       input logic d, input logic [1:0] o);
    case (sel)
      0: begin bus3.start = s;  bus3.A = a;     bus3.B = b;     bus3.dir = d;  bus3.op = o;  end
      1: begin bus3e.start = s; bus3e.A = a;    bus3e.B = b;    bus3e.dir = d; bus3e.op = o; end
      default: begin bus1.start = s; bus1.A = a[0]; bus1.B = b[0]; bus1.dir = d; bus1.op = o; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus3.done : (sel == 1) ? bus3e.done : bus1.done;
  endfunction

  function automatic logic get_zout(input int sel);
    return (sel == 0) ? bus3.Zout : (sel == 1) ? bus3e.Zout : bus1.Zout;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus3.busy : (sel == 1) ? bus3e.busy : bus1.busy;
  endfunction

  function automatic logic golden(input logic [2:0] a, input logic [2:0] b, input logic [1:0] o);
    case (o)
      OP_LE:   return a <= b;
      OP_LT:   return a <  b;
      OP_EQ:   return a == b;
      default: return a >= b;
    endcase
  endfunction

  // Entered at a negedge in IDLE; leaves at the negedge of the first IDLE
  // cycle after done, so consecutive calls exercise back-to-back starts.
  task automatic run_op(input int sel, input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic d, input logic [1:0] o, input bit hold,
                        input logic ez, input int exp_lat);
    int          lat;
    logic [31:0] e;
    exp_q.push_back(32'(ez));
    drive(sel, 1'b1, a, b, d, o);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"}, 32'(get_zout(sel)), 32'(last_z[sel]));
    if (hold) drive(sel, 1'b1, 3'b000, ~b, ~d, ~o);
    else      drive(sel, 1'b0, a, b, d, o);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        lat = k;
        break;
      end
    end
    drive(sel, 1'b0, a, b, d, o);
    e = exp_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_z"}, 32'(get_zout(sel)), e);
    check({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
    @(negedge clk);
    check({tag, "_width"}, 32'(get_done(sel)), 32'd0);
    check({tag, "_zhold"}, 32'(get_zout(sel)), e);
    last_z[sel] = e[0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 3'b000, 3'b000, 1'b0, OP_LE);
      last_z[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus3.busy),   32'd0);
    check("rst_done",  32'(bus3.done),   32'd0);
    check("rst_zout",  32'(bus3.Zout),   32'd0);
    check("rst_state", 32'(bus3.estado), 32'(ST_IDLE));
    check("rst_cmp",   32'(bus3.cmp_dbg), 32'(CMP_EQ));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic LSB-first LE on N=3.
    run_op(0, "le_101_110", 3'b101, 3'b110, 1'b0, OP_LE, 1'b0, 1'b1, 3);
    run_op(0, "le_110_101", 3'b110, 3'b101, 1'b0, OP_LE, 1'b0, 1'b0, 3);
    run_op(0, "le_111_111", 3'b111, 3'b111, 1'b0, OP_LE, 1'b0, 1'b1, 3);

    // Reset in the second RUN cycle, seen without a clock edge.
    drive(0, 1'b1, 3'b101, 3'b110, 1'b0, OP_LE);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 3'b101, 3'b110, 1'b0, OP_LE);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus3.busy),   32'd0);
    check("mid_rst_done",  32'(bus3.done),   32'd0);
    check("mid_rst_zout",  32'(bus3.Zout),   32'd0);
    check("mid_rst_state", 32'(bus3.estado), 32'(ST_IDLE));
    last_z[0] = 1'b0;
    last_z[1] = 1'b0;
    last_z[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, "post_rst", 3'b011, 3'b010, 1'b1, OP_GE, 1'b0, 1'b1, 3);

    // Start held through RUN while inputs change: first operands win.
    run_op(0, "hold_a", 3'b110, 3'b101, 1'b0, OP_GE, 1'b1, 1'b1, 3);
    run_op(0, "b2b_eq", 3'b010, 3'b010, 1'b1, OP_EQ, 1'b0, 1'b1, 3);
    run_op(0, "b2b_lt", 3'b001, 3'b100, 1'b1, OP_LT, 1'b0, 1'b1, 3);

    // Early exit build, MSB-first LE.
    run_op(1, "ee_100_000", 3'b100, 3'b000, 1'b1, OP_LE, 1'b0, 1'b0, 1);
    run_op(1, "ee_010_011", 3'b010, 3'b011, 1'b1, OP_LE, 1'b0, 1'b1, 3);
    run_op(1, "ee_111_111", 3'b111, 3'b111, 1'b1, OP_LE, 1'b0, 1'b1, 3);
    run_op(1, "ee_010_000", 3'b010, 3'b000, 1'b1, OP_GE, 1'b0, 1'b1, 2);
    run_op(1, "ee_lsb_100", 3'b100, 3'b000, 1'b0, OP_LE, 1'b0, 1'b0, 3);

    // N=1 build.
    run_op(2, "n1_ge_1_0", 3'b001, 3'b000, 1'b0, OP_GE, 1'b0, 1'b1, 1);
    run_op(2, "n1_ge_0_1", 3'b000, 3'b001, 1'b0, OP_GE, 1'b0, 1'b0, 1);
    run_op(2, "n1_eq_1_1", 3'b001, 3'b001, 1'b1, OP_EQ, 1'b0, 1'b1, 1);

    // Every operand pair, relation and direction on the N=3 build.
    for (int d = 0; d < 2; d++) begin
      for (int o = 0; o < 4; o++) begin
        for (int a = 0; a < 8; a++) begin
          for (int b = 0; b < 8; b++) begin
            run_op(0, $sformatf("ex_d%0d_o%0d_a%0d_b%0d", d, o, a, b), 3'(a), 3'(b), 1'(d), 2'(o),
                   1'b0, golden(3'(a), 3'(b), 2'(o)), 3);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
